// File: rtl/square_wave_synth.sv
// Square-wave sample generator: half-period in 48 kHz ticks -> signed samples over valid/ready.
// Define SQW_AMP_RAMP_EN to enable the per-period attack/release amplitude ramp.
module square_wave_synth #(
    parameter int                  SAMPLE_W  = 24,
    parameter int                  HP_W      = 8,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE = 24'h100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic [HP_W-1:0]     half_period,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                note_active,
    output logic                overrun
);

`ifdef SQW_AMP_RAMP_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_RELEASE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1} state_t;
`endif

    localparam logic [SAMPLE_W-1:0] STEP    = AMPLITUDE >> 4;
    localparam logic [SAMPLE_W-1:0] ZERO_S  = {SAMPLE_W{1'b0}};
    localparam logic [HP_W-1:0]     HP_ZERO = {HP_W{1'b0}};
    localparam logic [HP_W-1:0]     HP_ONE  = {{(HP_W-1){1'b0}}, 1'b1};
`ifdef SQW_AMP_RAMP_EN
    localparam logic [SAMPLE_W-1:0] START_AMP = STEP;
`else
    localparam logic [SAMPLE_W-1:0] START_AMP = AMPLITUDE;
`endif

    function automatic logic [SAMPLE_W-1:0] neg_sample(input logic [SAMPLE_W-1:0] mag);
        neg_sample = ZERO_S - mag;
    endfunction

    function automatic logic [SAMPLE_W-1:0] amp_up(input logic [SAMPLE_W-1:0] mag);
        if (mag >= (AMPLITUDE - STEP)) begin
            amp_up = AMPLITUDE;
        end else begin
            amp_up = mag + STEP;
        end
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [HP_W-1:0]       cnt_r;
    logic [HP_W-1:0]       cnt_next_s;
    logic                  phase_r;
    logic                  phase_next_s;
    logic [HP_W-1:0]       active_hp_r;
    logic [HP_W-1:0]       active_hp_next_s;
    logic [SAMPLE_W-1:0]   amp_cur_s;
    logic [SAMPLE_W-1:0]   emit_s;
    logic                  wrap_s;
    logic                  running_s;
    logic                  hp_zero_s;
    logic [SAMPLE_W-1:0]   sample_data_r;
    logic                  sample_valid_r;
    logic                  note_active_r;
    logic                  overrun_r;
`ifdef SQW_AMP_RAMP_EN
    logic [SAMPLE_W-1:0]   amp_r;
    logic [SAMPLE_W-1:0]   amp_next_s;

    assign amp_cur_s = amp_r;
    assign running_s = (state_r == ST_RUN) || (state_r == ST_RELEASE);
`else
    assign amp_cur_s = AMPLITUDE;
    assign running_s = (state_r == ST_RUN);
`endif

    assign wrap_s    = (cnt_r == (active_hp_r - HP_ONE));
    assign hp_zero_s = (half_period == HP_ZERO);

    // Waveform state register; only advances through the next-state logic on ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= HP_ZERO;
            phase_r     <= 1'b0;
            active_hp_r <= HP_ZERO;
`ifdef SQW_AMP_RAMP_EN
            amp_r       <= ZERO_S;
`endif
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            phase_r     <= phase_next_s;
            active_hp_r <= active_hp_next_s;
`ifdef SQW_AMP_RAMP_EN
            amp_r       <= amp_next_s;
`endif
        end
    end

    // Next-state logic: counting, phase toggles and period-boundary decisions.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        phase_next_s     = phase_r;
        active_hp_next_s = active_hp_r;
`ifdef SQW_AMP_RAMP_EN
        amp_next_s       = amp_r;
`endif
        if (!sample_tick) begin
            state_next_s = state_r;
        end else if (state_r == ST_IDLE) begin
            if (!hp_zero_s) begin
                // The starting tick is itself the first high sample of the period.
                state_next_s     = ST_RUN;
                active_hp_next_s = half_period;
`ifdef SQW_AMP_RAMP_EN
                amp_next_s       = STEP;
`endif
                if (half_period == HP_ONE) begin
                    cnt_next_s   = HP_ZERO;
                    phase_next_s = 1'b1;
                end else begin
                    cnt_next_s   = HP_ONE;
                    phase_next_s = 1'b0;
                end
            end else begin
                state_next_s = ST_IDLE;
            end
        end else if (running_s) begin
            if (wrap_s) begin
                cnt_next_s   = HP_ZERO;
                phase_next_s = ~phase_r;
                if (phase_r) begin
                    if (!hp_zero_s) begin
                        active_hp_next_s = half_period;
                        state_next_s     = ST_RUN;
`ifdef SQW_AMP_RAMP_EN
                        amp_next_s       = amp_up(amp_r);
`endif
                    end else begin
`ifdef SQW_AMP_RAMP_EN
                        if (amp_r <= STEP) begin
                            amp_next_s   = ZERO_S;
                            state_next_s = ST_IDLE;
                        end else begin
                            amp_next_s   = amp_r - STEP;
                            state_next_s = ST_RELEASE;
                        end
`else
                        state_next_s = ST_IDLE;
`endif
                    end
                end else begin
                    state_next_s = state_r;
                end
            end else begin
                cnt_next_s = cnt_r + HP_ONE;
            end
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // Sample value produced by the current tick.
    always_comb begin
        emit_s = ZERO_S;
        case (state_r)
            ST_IDLE: begin
                if (!hp_zero_s) begin
                    emit_s = START_AMP;
                end else begin
                    emit_s = ZERO_S;
                end
            end
            ST_RUN: begin
                if (phase_r) begin
                    emit_s = neg_sample(amp_cur_s);
                end else begin
                    emit_s = amp_cur_s;
                end
            end
`ifdef SQW_AMP_RAMP_EN
            ST_RELEASE: begin
                if (phase_r) begin
                    emit_s = neg_sample(amp_cur_s);
                end else begin
                    emit_s = amp_cur_s;
                end
            end
`endif
            default: emit_s = ZERO_S;
        endcase
    end

    // Output stage: sample hand-off, sticky overrun and note activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data_r  <= ZERO_S;
            sample_valid_r <= 1'b0;
            note_active_r  <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            note_active_r <= (state_next_s != ST_IDLE);
            if (sample_tick) begin
                sample_data_r  <= emit_s;
                sample_valid_r <= 1'b1;
                overrun_r      <= overrun_r | (sample_valid_r & ~sample_ready);
            end else if (sample_valid_r && sample_ready) begin
                sample_valid_r <= 1'b0;
            end
        end
    end

    assign sample_data  = sample_data_r;
    assign sample_valid = sample_valid_r;
    assign note_active  = note_active_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_square_wave_synth.sv
// Directed bench for square_wave_synth: period-level reference model checked every cycle,
// plus hand-computed sample sequences.
module tb_square_wave_synth;
    localparam logic [23:0] P = 24'h100000;
    localparam logic [23:0] N = 24'hF00000;
    localparam logic [23:0] Z = 24'h000000;
    localparam int          AMP_I  = 32'h100000;
    localparam int          STEP_I = 32'h010000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic [7:0]  half_period;
    logic        sample_ready;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic        note_active;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    square_wave_synth dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .half_period  (half_period),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .note_active  (note_active),
        .overrun      (overrun)
    );

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %06h expected %06h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a period is 2*hp ticks, first hp high; level steps per period when ramping.
    int          m_hp, m_pos, m_lvl, m_s, m_amp;
    logic        m_active, m_valid, m_ovr;
    logic [23:0] m_data;
    logic        cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_hp = 0; m_pos = 0; m_lvl = 0;
            m_active = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_data = Z;
        end else if (sample_tick) begin
            if (!m_active && half_period != 8'd0) begin
                m_active = 1'b1; m_hp = int'(half_period); m_pos = 0; m_lvl = 1;
            end
            if (m_active) begin
`ifdef SQW_AMP_RAMP_EN
                m_amp = m_lvl * STEP_I;
`else
                m_amp = AMP_I;
`endif
                m_s = (m_pos < m_hp) ? m_amp : -m_amp;
                m_pos = m_pos + 1;
                if (m_pos == 2 * m_hp) begin
                    m_pos = 0;
                    if (half_period == 8'd0) begin
`ifdef SQW_AMP_RAMP_EN
                        m_lvl = m_lvl - 1;
                        if (m_lvl == 0) m_active = 1'b0;
`else
                        m_active = 1'b0;
`endif
                    end else begin
                        m_hp = int'(half_period);
                        if (m_lvl < 16) m_lvl = m_lvl + 1;
                    end
                end
            end else begin
                m_s = 0;
            end
            if (m_valid && !sample_ready) m_ovr = 1'b1;
            m_data  = m_s[23:0];
            m_valid = 1'b1;
        end else if (m_valid && sample_ready) begin
            m_valid = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_data",  sample_data,       m_data);
            chk("model_valid", 24'(sample_valid), 24'(m_valid));
            chk("model_note",  24'(note_active),  24'(m_active));
            chk("model_ovr",   24'(overrun),      24'(m_ovr));
        end
    end

    logic [23:0] got[$];
    logic        nt[$];

    task automatic do_tick(input logic [7:0] hp, input logic rdy);
        sample_tick = 1'b1; half_period = hp; sample_ready = rdy;
        @(negedge clk);
        sample_tick = 1'b0;
        got.push_back(sample_data);
        nt.push_back(note_active);
        chk("latency_valid", 24'(sample_valid), 24'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n, input logic [7:0] hp, input logic rdy);
        for (int i = 0; i < n; i++) do_tick(hp, rdy);
    endtask

    task automatic pulse_rst();
        rst = 1'b1; sample_tick = 1'b0; sample_ready = 1'b1; half_period = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 24'(sample_valid), 24'd0);
        chk("rst_note",  24'(note_active),  24'd0);
        chk("rst_ovr",   24'(overrun),      24'd0);
        chk("rst_data",  sample_data,       Z);
        got.delete(); nt.delete();
    endtask

    initial begin
        rst = 1'b1; sample_tick = 1'b0; half_period = 8'd0; sample_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_data",  sample_data,       Z);
        chk("reset_valid", 24'(sample_valid), 24'd0);
        chk("reset_note",  24'(note_active),  24'd0);
        chk("reset_ovr",   24'(overrun),      24'd0);

        // Silence: ten zero samples.
        run_ticks(10, 8'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("silence_data", got[i], Z);
            chk("silence_note", 24'(nt[i]), 24'd0);
        end
        chk("silence_ovr", 24'(overrun), 24'd0);

        // Basic shape hp=3, then release: the running period completes, then zeros.
        got.delete(); nt.delete();
        run_ticks(12, 8'd3, 1'b1);
        run_ticks(8, 8'd0, 1'b1);
        for (int i = 0; i < 18; i++) chk("shape3", got[i], ((i % 6) < 3) ? P : N);
        chk("shape3_tail0", got[18], Z);
        chk("shape3_tail1", got[19], Z);
        chk("shape3_note_before", 24'(nt[16]), 24'd1);
        chk("shape3_note_after",  24'(nt[17]), 24'd0);

        // Mid-period change 3->2 after the 2nd tick.
        pulse_rst();
        run_ticks(2, 8'd3, 1'b1);
        run_ticks(8, 8'd2, 1'b1);
        chk("chg0", got[0], P); chk("chg2", got[2], P); chk("chg3", got[3], N);
        chk("chg5", got[5], N); chk("chg6", got[6], P); chk("chg7", got[7], P);
        chk("chg8", got[8], N); chk("chg9", got[9], N);

        // Release 4->0 after the 5th tick.
        pulse_rst();
        run_ticks(5, 8'd4, 1'b1);
        run_ticks(5, 8'd0, 1'b1);
        chk("rel3", got[3], P); chk("rel4", got[4], N); chk("rel7", got[7], N);
        chk("rel8", got[8], Z); chk("rel9", got[9], Z);
        chk("rel_note6", 24'(nt[6]), 24'd1);
        chk("rel_note7", 24'(nt[7]), 24'd0);

        // Handshake: hp=1 alternates; stall, same-cycle accept, overrun.
        pulse_rst();
        run_ticks(2, 8'd1, 1'b1);
        chk("alt0", got[0], P); chk("alt1", got[1], N);
        do_tick(8'd1, 1'b0);
        chk("stall_valid", 24'(sample_valid), 24'd1);
        chk("stall_data",  sample_data, P);
        do_tick(8'd1, 1'b1);
        chk("accept_tick_data", got[3], N);
        chk("accept_tick_ovr",  24'(overrun), 24'd0);
        do_tick(8'd1, 1'b0);
        do_tick(8'd1, 1'b0);
        chk("ovr_data",  sample_data, N);
        chk("ovr_valid", 24'(sample_valid), 24'd1);
        chk("ovr_flag",  24'(overrun), 24'd1);
        sample_ready = 1'b1;
        @(negedge clk);
        chk("ovr_drain_valid", 24'(sample_valid), 24'd0);
        chk("ovr_sticky",      24'(overrun), 24'd1);
        run_ticks(2, 8'd1, 1'b1);
        chk("ovr_sticky2", 24'(overrun), 24'd1);
        pulse_rst();

`ifdef SQW_AMP_RAMP_EN
        // Attack ramp to full scale, then release decay back to idle.
        run_ticks(40, 8'd1, 1'b1);
        run_ticks(34, 8'd0, 1'b1);
        chk("ramp0",  got[0],  24'h010000);
        chk("ramp1",  got[1],  24'hFF0000);
        chk("ramp2",  got[2],  24'h020000);
        chk("ramp30", got[30], P);
        chk("ramp39", got[39], N);
        chk("ramp40", got[40], P);
        chk("decay42", got[42], 24'h0F0000);
        chk("decay70", got[70], 24'h010000);
        chk("decay71", got[71], 24'hFF0000);
        chk("decay72", got[72], Z);
        chk("decay_note", 24'(nt[72]), 24'd0);
`endif

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
